// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM with byte enables, registered read, error strobe and an
// optional post-reset clear sweep enabled by the RAM_CLR_ON_RST_EN macro.
module ram_sp_param #(
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 10,
   parameter int unsigned DEPTH = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cs,
   input  logic            wr,
   input  logic            rd,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] be,
   output logic [DW-1:0]   rdata,
   output logic            rvalid,
   output logic            busy,
   output logic            err
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];

   logic [IW-1:0] idx;
   logic [IW-1:0] clr_idx;
   logic          clr_we;
   logic          busy_int;
   logic          req;
   logic          in_range;
   logic          acc_wr;
   logic          acc_rd;
   logic          err_d;

   assign idx = addr[IW-1:0];

`ifdef RAM_CLR_ON_RST_EN
   typedef enum logic {StClear, StIdle} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      clr_we    = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_we    = 1'b1;
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
               state_d   = StIdle;
               clr_ptr_d = '0;
            end
         end
         StIdle: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_int = (state_q == StClear);
   assign clr_idx  = clr_ptr_q[IW-1:0];
`else
   assign busy_int = 1'b0;
   assign clr_we   = 1'b0;
   assign clr_idx  = '0;
`endif

   // Anything requested but not accepted (busy, rd+wr collision, out of range) flags err.
   always_comb begin
      req      = cs & (rd | wr);
      in_range = 32'(addr) < DEPTH;
      acc_wr   = req & ~busy_int & ~rd & in_range;
      acc_rd   = req & ~busy_int & ~wr & in_range;
      err_d    = req & ~(acc_wr | acc_rd);
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (acc_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= acc_rd;
         err    <= err_d;
         if (acc_rd) rdata <= mem[idx];
      end
   end

   assign busy = busy_int;

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench for ram_sp_param: driver pushes expected read data / error strobes,
// a negedge monitor pops and compares them against rvalid and err.
module tb_ram_sp_param;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 12;
`ifdef RAM_CLR_ON_RST_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          cs    = 1'b0;
   logic          wr    = 1'b0;
   logic          rd    = 1'b0;
   logic [AW-1:0] addr  = '0;
   logic [DW-1:0] wdata = '0;
   logic [3:0]    be    = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          busy;
   logic          err;

   ram_sp_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cs     (cs),
      .wr     (wr),
      .rd     (rd),
      .addr   (addr),
      .wdata  (wdata),
      .be     (be),
      .rdata  (rdata),
      .rvalid (rvalid),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            at;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t       rq[$];
   int            eq[$];
   logic [DW-1:0] model [DEPTH];
   bit            model_busy = 1'b0;
   logic [DW-1:0] hold = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_in(input logic c, input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] b);
      cs = c; wr = w; rd = r; addr = a; wdata = d; be = b;
   endtask

   // Reference behaviour: decide the request's fate from the rules and queue the response.
   task automatic drive(input logic c, input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] b);
      set_in(c, w, r, a, d, b);
      if (c && (w || r)) begin
         if (model_busy || (w && r) || int'(a) >= int'(DEPTH)) begin
            eq.push_back(cyc + 1);
         end else if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
         end else begin
            rq.push_back('{at: cyc + 1, data: model[a]});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) tick();
      check("rd_queue_drained", 64'(rq.size()), 64'd0);
      check("err_queue_drained", 64'(eq.size()), 64'd0);
   endtask

   task automatic release_and_measure(input bit probe);
      int n;
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      model_busy = CLR;
      if (CLR) for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      n = 0;
      if (probe) begin
         drive(1'b1, 1'b0, 1'b1, 4'd2, '0, '0);
         tick();
         set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
         n = 1;
      end
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("busy_cycles", 64'(n), CLR ? 64'(DEPTH) : (probe ? 64'd1 : 64'd0));
      model_busy = 1'b0;
   endtask

   always @(negedge rst_n) hold = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         bit exp_rv, exp_err;
         while (rq.size() > 0 && rq[0].at < cyc) begin
            check("stale_read_exp", 64'(rq[0].at), 64'(cyc));
            void'(rq.pop_front());
         end
         while (eq.size() > 0 && eq[0] < cyc) begin
            check("stale_err_exp", 64'(eq[0]), 64'(cyc));
            void'(eq.pop_front());
         end
         exp_rv = rq.size() > 0 && rq[0].at == cyc;
         check("rvalid", 64'(rvalid), 64'(exp_rv));
         if (exp_rv) begin
            rd_exp_t e;
            e = rq.pop_front();
            check("rdata", 64'(rdata), 64'(e.data));
            hold = e.data;
         end else begin
            check("rdata_hold", 64'(rdata), 64'(hold));
         end
         exp_err = eq.size() > 0 && eq[0] == cyc;
         check("err", 64'(err), 64'(exp_err));
         if (exp_err) void'(eq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("reset_rdata", 64'(rdata), 64'd0);
      check("reset_rvalid", 64'(rvalid), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_busy", 64'(busy), 64'(CLR));
      release_and_measure(1'b0);

      // Without the sweep the contents are undefined, so give every word a value first.
      if (!CLR) begin
         for (int a = 0; a < int'(DEPTH); a++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(a), $urandom, 4'hF);
            tick();
         end
      end
      for (int a = 0; a < int'(DEPTH); a++) begin
         drive(1'b1, 1'b0, 1'b1, AW'(a), '0, '0);
         tick();
      end
      drain();

      drive(1'b1, 1'b1, 1'b0, 4'd5, 32'hAABBCCDD, 4'hF);
      tick();
      drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h11223344, 4'b0101);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd5, '0, '0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("byte_merge_const", 64'(rdata), 64'h00000000AA22CC44);
      drive(1'b1, 1'b1, 1'b0, 4'd6, 32'hFFFFFFFF, 4'h0);
      tick();
      drain();

      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h0BADF00D, 4'hF);
      tick();
      drive(1'b1, 1'b1, 1'b1, 4'd3, 32'h12345678, 4'hF);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd3, '0, '0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("collision_keeps_mem", 64'(rdata), 64'h000000000BADF00D);
      drain();

      drive(1'b1, 1'b1, 1'b0, 4'd13, 32'hDEADBEEF, 4'hF);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd11, '0, '0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd13, '0, '0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd15, '0, '0);
      tick();
      drain();

      drive(1'b1, 1'b1, 1'b0, 4'd0, 32'h5A5A5A5A, 4'hF);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd0, '0, '0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 4'd1, '0, '0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drain();

      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom),
               AW'($urandom_range(0, 15)), $urandom, 4'($urandom));
         tick();
      end
      drain();

      // Reset while a read result is being presented.
      set_in(1'b1, 1'b0, 1'b1, 4'd4, '0, '0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      check("rvalid_before_reset", 64'(rvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rvalid_async_clear", 64'(rvalid), 64'd0);
      check("rdata_async_clear", 64'(rdata), 64'd0);
      #20;
      if (CLR) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         repeat (7) tick();
         check("busy_mid_sweep", 64'(busy), 64'd1);
         rst_n = 1'b0;
         #20;
      end
      release_and_measure(1'b1);
      for (int a = 0; a < int'(DEPTH); a++) begin
         drive(1'b1, 1'b0, 1'b1, AW'(a), '0, '0);
         tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
